// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction buffer, circular FIFO of (pc+4, instr) pairs
// with valid/ready on both sides and a synchronous flush for taken branches.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc4,
    input  logic [WIDTH-1:0] in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc4,
    output logic [WIDTH-1:0] out_instr,
    output logic [PTR_W:0]   count
);
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               push, pop;

    assign in_ready  = count != (PTR_W+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {out_pc4, out_instr} = out_valid ? mem[rd_ptr] : '0;

    // storage is deliberately left unreset; the pointers alone define what is valid
    always_ff @(posedge clock)
        if (push && !flush)
            mem[wr_ptr] <= {in_pc4, in_instr};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end
endmodule
